// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the sync_fifo_ext family.
// Parameter legality is evaluated here so every FIFO variant applies the same rules.
package fifo_pkg;

  typedef enum logic {
    FIFO_REG  = 1'b0,
    FIFO_FWFT = 1'b1
  } read_mode_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit depth_legal(input int depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

  function automatic bit af_legal(input int depth, input int af_thresh);
    return (af_thresh >= 1) && (af_thresh <= depth);
  endfunction

  function automatic bit ae_legal(input int depth, input int ae_thresh);
    return (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

  function automatic bit mode_legal(input int fwft);
    return (fwft == 0) || (fwft == 1);
  endfunction

  function automatic read_mode_e to_read_mode(input int fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_REG;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DataWidth x Depth storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int DataWidth = 64,
  parameter int Depth     = 256,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];

  // Contents are intentionally never reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with registered or fall-through read, programmable thresholds,
// occupancy count, write-at-full with concurrent pop, and sticky error flags.
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int Depth     = 256,
  parameter int AfThresh  = Depth - 4,
  parameter int AeThresh  = 4,
  parameter int Fwft      = 0,
  parameter int PtrWidth  = ptr_width(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 writeEn,
  input  logic [DataWidth-1:0] writeData,
  input  logic                 readEn,
  output logic [DataWidth-1:0] readData,
  output logic                 full,
  output logic                 empty,
  output logic                 almostFull,
  output logic                 almostEmpty,
  output logic [PtrWidth:0]    count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clrErr
);

  localparam read_mode_e        ReadMode = to_read_mode(Fwft);
  localparam logic [PtrWidth:0] AfLevel  = (PtrWidth + 1)'(AfThresh);
  localparam logic [PtrWidth:0] AeLevel  = (PtrWidth + 1)'(AeThresh);
  localparam logic [PtrWidth:0] PtrOne   = (PtrWidth + 1)'(1);

  if (!depth_legal(Depth)) begin : g_bad_depth
    $error("sync_fifo_ext: Depth must be a power of two and at least 4");
  end
  if (!af_legal(Depth, AfThresh)) begin : g_bad_af
    $error("sync_fifo_ext: AfThresh must lie in 1..Depth");
  end
  if (!ae_legal(Depth, AeThresh)) begin : g_bad_ae
    $error("sync_fifo_ext: AeThresh must lie in 0..Depth-1");
  end
  if (!mode_legal(Fwft)) begin : g_bad_mode
    $error("sync_fifo_ext: Fwft must be 0 or 1");
  end
  if (PtrWidth != ptr_width(Depth)) begin : g_bad_ptr
    $error("sync_fifo_ext: PtrWidth is derived from Depth and must not be overridden");
  end

  logic [PtrWidth:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrWidth:0]    rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 rd_acc, wr_acc;
  logic                 ram_wr_en;
  logic                 full_int, empty_int;
  logic [PtrWidth:0]    count_int;
  logic [DataWidth-1:0] ram_rd_data;

  // Status comes straight from the registered pointers, so it never glitches.
  assign full_int  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                     (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
  assign empty_int = (wr_ptr_q == rd_ptr_q);
  assign count_int = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same cycle, so a write at full may ride along with it.
  assign rd_acc    = readEn && !empty_int;
  assign wr_acc    = writeEn && (!full_int || rd_acc);
  assign ram_wr_en = wr_acc && !rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (rst) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      overflow_d  = (overflow_q && !clrErr) || (writeEn && !wr_acc);
      underflow_d = (underflow_q && !clrErr) || (readEn && empty_int);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  fifo_ram #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (PtrWidth)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[PtrWidth-1:0]),
    .wr_data (writeData),
    .rd_addr (rd_ptr_q[PtrWidth-1:0]),
    .rd_data (ram_rd_data)
  );

  if (ReadMode == FIFO_FWFT) begin : g_fwft
    assign readData = ram_rd_data;
  end else begin : g_reg
    logic [DataWidth-1:0] read_data_q, read_data_d;

    // Registered mode captures the head as it is popped and holds it until the next pop.
    always_comb begin
      read_data_d = read_data_q;
      if (rst) begin
        read_data_d = '0;
      end else if (rd_acc) begin
        read_data_d = ram_rd_data;
      end
    end

    always_ff @(posedge clk) begin
      read_data_q <= read_data_d;
    end

    assign readData = read_data_q;
  end

  assign full        = full_int;
  assign empty       = empty_int;
  assign count       = count_int;
  assign almostFull  = (count_int >= AfLevel);
  assign almostEmpty = (count_int <= AeLevel);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Drives a registered-read and a fall-through instance with identical stimulus and
// compares both against a queue-based reference model.
module tb_sync_fifo_ext;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int PW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          write_en;
  logic [DW-1:0] write_data;
  logic          read_en;
  logic          clr_err;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1;
  logic [PW:0]   count0, count1;
  logic          ovf0, ovf1, udf0, udf1;

  int tests_run;
  int tests_failed;

  logic [DW-1:0] model_q[$];
  logic          model_ovf;
  logic          model_udf;
  logic [DW-1:0] model_rd;

  sync_fifo_ext #(
    .DataWidth (DW), .Depth (DEPTH), .AfThresh (AF), .AeThresh (AE), .Fwft (0)
  ) dut_reg (
    .clk (clk), .rst (rst), .writeEn (write_en), .writeData (write_data),
    .readEn (read_en), .readData (rd_data0), .full (full0), .empty (empty0),
    .almostFull (af0), .almostEmpty (ae0), .count (count0),
    .overflow (ovf0), .underflow (udf0), .clrErr (clr_err)
  );

  sync_fifo_ext #(
    .DataWidth (DW), .Depth (DEPTH), .AfThresh (AF), .AeThresh (AE), .Fwft (1)
  ) dut_fwft (
    .clk (clk), .rst (rst), .writeEn (write_en), .writeData (write_data),
    .readEn (read_en), .readData (rd_data1), .full (full1), .empty (empty1),
    .almostFull (af1), .almostEmpty (ae1), .count (count1),
    .overflow (ovf1), .underflow (udf1), .clrErr (clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model follows the behavioural rules directly: a queue that pops before it pushes.
  task automatic updateModel(input logic we, input logic [DW-1:0] wd, input logic re,
                             input logic clr, input logic rs);
    bit was_empty, was_full, rd_ok, wr_ok;
    if (rs) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_udf = 1'b0;
      model_rd  = '0;
    end else begin
      was_empty = (model_q.size() == 0);
      was_full  = (model_q.size() == DEPTH);
      rd_ok     = re && !was_empty;
      wr_ok     = we && (!was_full || rd_ok);
      if (rd_ok) model_rd = model_q.pop_front();
      if (wr_ok) model_q.push_back(wd);
      model_ovf = (model_ovf && !clr) || (we && !wr_ok);
      model_udf = (model_udf && !clr) || (re && was_empty);
    end
  endtask

  task automatic checkOutput();
    int n;
    n = model_q.size();
    checkEq("count_reg",  32'(count0), 32'(n));
    checkEq("count_fwft", 32'(count1), 32'(n));
    checkEq("empty_reg",  32'(empty0), 32'(n == 0));
    checkEq("empty_fwft", 32'(empty1), 32'(n == 0));
    checkEq("full_reg",   32'(full0),  32'(n == DEPTH));
    checkEq("full_fwft",  32'(full1),  32'(n == DEPTH));
    checkEq("af_reg",     32'(af0),    32'(n >= AF));
    checkEq("af_fwft",    32'(af1),    32'(n >= AF));
    checkEq("ae_reg",     32'(ae0),    32'(n <= AE));
    checkEq("ae_fwft",    32'(ae1),    32'(n <= AE));
    checkEq("ovf_reg",    32'(ovf0),   32'(model_ovf));
    checkEq("ovf_fwft",   32'(ovf1),   32'(model_ovf));
    checkEq("udf_reg",    32'(udf0),   32'(model_udf));
    checkEq("udf_fwft",   32'(udf1),   32'(model_udf));
    checkEq("rdata_reg",  32'(rd_data0), 32'(model_rd));
    if (n != 0) begin
      checkEq("rdata_fwft", 32'(rd_data1), 32'(model_q[0]));
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [DW-1:0] wd, input logic re,
                               input logic clr, input logic rs);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    clr_err    = clr;
    rst        = rs;
    @(posedge clk);
    updateModel(we, wd, re, clr, rs);
    #1;
    checkOutput();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_ovf    = 1'b0;
    model_udf    = 1'b0;
    model_rd     = '0;
    write_en     = 1'b0;
    write_data   = '0;
    read_en      = 1'b0;
    clr_err      = 1'b0;
    rst          = 1'b1;
    #1;

    // Reset, then an idle cycle.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill with 0x11..0x18, then one write too many.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, DW'(16'h11 + i), 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 16'h0099, 1'b0, 1'b0, 1'b0);

    // Write at full together with a pop; the new word wraps into slot 0.
    applyStimulus(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Drain completely, read once more while empty, then clear the error.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Single word into an empty FIFO: visible in fall-through mode without a pop.
    applyStimulus(1'b1, 16'h005A, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Write into empty with a simultaneous read request: no bypass, underflow set.
    applyStimulus(1'b1, 16'h0077, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, DW'(16'h0030 + i), 1'b0, 1'b0, 1'b0);
    end

    // Reset while half full with a write pending.
    applyStimulus(1'b1, 16'h00EE, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic with phases biased toward filling, draining, then mixed.
    for (int i = 0; i < 450; i++) begin
      int wp;
      wp = (i < 150) ? 75 : ((i < 300) ? 25 : 50);
      applyStimulus($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < (100 - wp),
                    $urandom_range(15) == 0, $urandom_range(127) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
